// File: rtl/seq_bus_datapath_if.sv
// seq_bus_datapath_if: control/handshake bundle between a control unit
// (master) and the single-bus datapath (slave).
//   start   : request, sampled only while the datapath is idle
//   op      : 4-bit operation code
//   ra/rb/rc: source A, source B and destination register indices
//   Mdatain : memory read data consumed by LDM
//   busy    : high while an instruction is in flight
//   done    : one-cycle completion pulse
//   err     : valid with done; 1 = illegal op, nothing written
interface seq_bus_datapath_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  localparam int RW = $clog2(NREGS);

  logic             start;
  logic [3:0]       op;
  logic [RW-1:0]    ra;
  logic [RW-1:0]    rb;
  logic [RW-1:0]    rc;
  logic [WIDTH-1:0] Mdatain;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, op, ra, rb, rc, Mdatain,
    input  busy, done, err
  );

  modport slave (
    input  start, op, ra, rb, rc, Mdatain,
    output busy, done, err
  );
endinterface

// File: rtl/seq_bus_datapath.sv
// seq_bus_datapath: single internal bus joining NREGS general registers,
// Y, a double-width Z, HI, LO and MDR, driven by an internal T-state
// sequencer so one start pulse runs a whole register-to-register op.
// Ports:
//   Clock    : rising-edge clock
//   Clear    : asynchronous active-low reset
//   ctl      : control/handshake bundle (slave side)
//   bus_out  : current internal bus value
//   hi_out   : HI register
//   lo_out   : LO register
//   dbg_sel  : debug register select
//   dbg_data : combinational read of R[dbg_sel]
module seq_bus_datapath #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic                     Clock,
  input  logic                     Clear,
  seq_bus_datapath_if.slave        ctl,
  output logic [WIDTH-1:0]         bus_out,
  output logic [WIDTH-1:0]         hi_out,
  output logic [WIDTH-1:0]         lo_out,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [WIDTH-1:0]         dbg_data
);
  localparam int RW  = $clog2(NREGS);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_LDM  = 4'd7;
  localparam logic [3:0] OP_MFHI = 4'd8;
  localparam logic [3:0] OP_MFLO = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_TM, S_TA, S_TB, S_TW, S_TH, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [RW-1:0]        ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [WIDTH-1:0]     regs_q [NREGS];
  logic [WIDTH-1:0]     regs_d [NREGS];
  logic [WIDTH-1:0]     y_q, y_d;
  logic [2*WIDTH-1:0]   z_q, z_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, mdr_q, mdr_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [WIDTH-1:0]     rd_a, rd_b, bus;
  logic [2*WIDTH-1:0]   alu_res;
  logic                 rc_writable;

  // With R0_ZERO set, R0 is a hardwired zero source and a sink for writes.
  assign rd_a        = (R0_ZERO && ra_q == '0) ? '0 : regs_q[ra_q];
  assign rd_b        = (R0_ZERO && rb_q == '0) ? '0 : regs_q[rb_q];
  assign rc_writable = !(R0_ZERO && rc_q == '0);

  // Bus source per state; MDR is the sole driver while memory data loads.
  always_comb begin
    bus = '0;
    case (state_q)
      S_TA: bus = rd_a;
      S_TB: bus = rd_b;
      S_TM: bus = mdr_q;
      S_TW: begin
        case (op_q)
          OP_LDM:  bus = mdr_q;
          OP_MFHI: bus = hi_q;
          OP_MFLO: bus = lo_q;
          default: bus = z_q[WIDTH-1:0];
        endcase
      end
      S_TH:    bus = z_q[2*WIDTH-1:WIDTH];
      default: bus = '0;
    endcase
  end

  // ALU: Y is operand A, the bus carries operand B during TB. Non-MUL
  // results leave the upper Z half at zero.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD: alu_res = {{WIDTH{1'b0}}, y_q + bus};
      OP_SUB: alu_res = {{WIDTH{1'b0}}, y_q - bus};
      OP_AND: alu_res = {{WIDTH{1'b0}}, y_q & bus};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, y_q | bus};
      OP_SHL: alu_res = {{WIDTH{1'b0}}, y_q << bus[SHW-1:0]};
      OP_SHR: alu_res = {{WIDTH{1'b0}}, y_q >> bus[SHW-1:0]};
      OP_MUL: alu_res = {{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, bus};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    // NOTE: every _d takes its _q value first so no path leaves a variable
    // unassigned; without these defaults synthesis would infer latches.
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    regs_d  = regs_q;
    y_d     = y_q;
    z_d     = z_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mdr_d   = mdr_q;

    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          op_d = ctl.op;
          ra_d = ctl.ra;
          rb_d = ctl.rb;
          rc_d = ctl.rc;
          case (ctl.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHL, OP_SHR, OP_MUL:  state_d = S_TA;
            OP_LDM:                  state_d = S_TM;
            OP_MFHI, OP_MFLO:        state_d = S_TW;
            default:                 state_d = S_DONE;
          endcase
        end
      end
      S_TA: begin
        y_d     = bus;
        state_d = S_TB;
      end
      S_TB: begin
        z_d     = alu_res;
        state_d = S_TW;
      end
      S_TM: begin
        mdr_d   = ctl.Mdatain;
        state_d = S_TW;
      end
      S_TW: begin
        if (op_q == OP_MUL) begin
          lo_d    = bus;
          state_d = S_TH;
        end else begin
          if (rc_writable) regs_d[rc_q] = bus;
          state_d = S_DONE;
        end
      end
      S_TH: begin
        hi_d    = bus;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered: computed from the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_DONE) && (op_d > OP_MFLO);
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      // NOTE: the register file must power up cleared, so it is built from
      // resettable flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      y_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mdr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      regs_q  <= regs_d;
      y_q     <= y_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mdr_q   <= mdr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ctl.busy = busy_q;
  assign ctl.done = done_q;
  assign ctl.err  = err_q;
  assign bus_out  = bus;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign dbg_data = (R0_ZERO && dbg_sel == '0) ? '0 : regs_q[dbg_sel];
endmodule

// File: doc/seq_bus_datapath.md
Name: seq_bus_datapath

Overview:
- Parametrised successor to the single-bus register/ALU/MDR datapath.
- Holds NREGS general registers plus Y, Z (2×WIDTH), HI, LO and MDR on one internal bus.
- Adds an internal T-state sequencer, so one start pulse executes a whole register-to-register instruction with no external per-cycle control strobes.
- Sits between the future control unit (issues op/ra/rb/rc) and memory (supplies Mdatain).

Parameters:
- WIDTH, 32, datapath/bus width in bits (≥8, power of two).
- NREGS, 16, number of general registers (power of two, ≥2).
- R0_ZERO, 0, 1 = R0 reads as 0 and ignores writes.

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  operation code (see Behaviour).
- ra  in  log2(NREGS)  source A register index.
- rb  in  log2(NREGS)  source B register index.
- rc  in  log2(NREGS)  destination register index.
- Mdatain  in  WIDTH  memory read data for LDM.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse in DONE state.
- err  out  1  valid with done; 1 = illegal op, no writes performed.
- bus_out  out  WIDTH  current internal bus value (observation).
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.
- dbg_sel  in  log2(NREGS)  debug register select.
- dbg_data  out  WIDTH  combinational read of R[dbg_sel]; 0 for R0 when R0_ZERO=1.

Behaviour:
- Reset (Clear=0, async):
  - All registers, Y, Z, HI, LO, MDR and the latched op/ra/rb/rc cleared to 0.
  - State = IDLE; busy=done=err=0.
  - Applies mid-operation: the in-flight op is abandoned with no further writes.
- Start acceptance:
  - In IDLE, start=1 at an edge latches op/ra/rb/rc and moves to the first T-state.
  - Inputs are ignored afterwards until IDLE; start while busy is ignored (not queued).
- Bus mux:
  - Exactly one source drives per state; bus=0 in IDLE/DONE.
  - Source set: R[i], HI, LO, Zlo, Zhi, MDR.
- Ops and state sequences (one state per cycle):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR: TA(bus=R[ra], Y<=bus) -> TB(bus=R[rb], Z<=ALU(Y,bus)) -> TW(bus=Zlo, R[rc]<=bus) -> DONE.
  - 6 MUL: TA -> TB(Z<=Y*bus, unsigned, full 2×WIDTH) -> TW(bus=Zlo, LO<=bus) -> TH(bus=Zhi, HI<=bus) -> DONE. No general register is written.
  - 7 LDM: TM(MDR<=Mdatain) -> TW(bus=MDR, R[rc]<=bus) -> DONE.
  - 8 MFHI / 9 MFLO: TW(bus=HI or LO, R[rc]<=bus) -> DONE.
  - 10–15 illegal: DONE directly with err=1; no state changes.
  - DONE -> IDLE unconditionally.
- Latency from accepting edge to done high: ALU 4 cycles, MUL 5, LDM 3, MFHI/MFLO 2, illegal 1.
- Next start is accepted in the cycle after DONE (IDLE).
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; Zhi=0 for non-MUL ops.
  - SHL/SHR are logical; shift amount = B[log2(WIDTH)-1:0].
- Register hazards:
  - ra=rb=rc is legal; sources are read in TA/TB, before the TW write.
- R0_ZERO=1:
  - R0 drives 0 onto the bus; writes with rc=0 are dropped, but the sequence and done still occur.
- err is held with done only; it is 0 at all other times.

Test Plan:
- Reset: Clear=0 mid-ADD (in TB) -> busy=0 immediately, all dbg_data=0, no write to rc after Clear releases.
- ALU: LDM R1<=0x0000_0005, LDM R2<=0x0000_0003; ADD rc=3 -> done 4 cycles after start, R3=8. SUB R4=R2-R1 -> 0xFFFF_FFFE.
- Shift/wrap: R1=0x8000_0001, R2=0x0000_0021; SHL -> shift amount 1 -> 0x0000_0002. ADD 0xFFFF_FFFF+1 -> 0.
- MUL/moves: R1=0xFFFF_FFFF, R2=2; MUL -> HI=0x0000_0001, LO=0xFFFF_FFFE, done after 5 cycles. MFHI rc=5 -> R5=1.
- Protocol: start held high through an op -> exactly one done per IDLE acceptance. Start during busy ignored. op=12 -> done+err at 1 cycle, no register change.
- R0_ZERO=1 build: LDM rc=0 with 0x1234 -> R0 still reads 0. ADD R1=R0+R2 -> R1=R2.
